// File: rtl/wb_bram_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-BRAM controller.
// Contents: FSM state encoding, the default BRAM window decode, and the
// bus widths.
package wb_bram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_CAPT  = 3'd3,
        ST_ACK   = 3'd4
    } state_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3800_0000;
    localparam logic [31:0] DEF_ADDR_MASK = 32'hFFC0_0000;
    localparam int          BRAM_WORD_W   = 32;
    localparam int          SEL_W         = 4;

endpackage

// File: rtl/wb_bram_ctrl_if.sv
// Bus bundle for wb_bram_ctrl: the Wishbone slave side plus the BRAM port.
// The slave modport is the controller's view. The master modport is the
// view of the bus master and the memory, which drive the inputs and observe
// the outputs.
//   wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i : Wishbone request
//   wbs_ack_o/err_o/dat_o                 : Wishbone response
//   bram_en/we/a/di                       : BRAM request (a = word index)
//   bram_do                               : BRAM read data, 1-cycle latency
interface wb_bram_ctrl_if;
    import wb_bram_pkg::*;

    logic                   wbs_cyc_i;
    logic                   wbs_stb_i;
    logic                   wbs_we_i;
    logic [SEL_W-1:0]       wbs_sel_i;
    logic [31:0]            wbs_adr_i;
    logic [BRAM_WORD_W-1:0] wbs_dat_i;
    logic                   wbs_ack_o;
    logic [BRAM_WORD_W-1:0] wbs_dat_o;
    logic                   wbs_err_o;
    logic                   bram_en;
    logic [SEL_W-1:0]       bram_we;
    logic [BRAM_WORD_W-1:0] bram_di;
    logic [BRAM_WORD_W-1:0] bram_do;
    logic [31:0]            bram_a;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  bram_do,
        output wbs_ack_o, wbs_dat_o, wbs_err_o,
        output bram_en, bram_we, bram_di, bram_a
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output bram_do,
        input  wbs_ack_o, wbs_dat_o, wbs_err_o,
        input  bram_en, bram_we, bram_di, bram_a
    );

endinterface

// File: rtl/wb_bram_ctrl_delay_cnt.sv
// Wait-state down-counter for wb_bram_ctrl.
// i_load presets the counter to DELAY-1, and i_dec steps it down by one.
// o_zero reports the terminal count.
// Ports: i_clk, i_rstn (synchronous, active-low), i_load, i_dec, o_zero.
module wb_bram_delay_cnt #(
    parameter int DELAY = 10
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);
    localparam int CW = $clog2(DELAY + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= CW'(DELAY - 1);
        else if (i_dec)
            r_cnt <= r_cnt - CW'(1);
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic-cycle slave that performs single-word BRAM accesses.
// Before each access it waits DELAY cycles, which makes the BRAM behave like
// slow external memory.
// Ports: wb_clk_i, wb_rstn_i (synchronous, active-low), and bus
// (wb_bram_ctrl_if.slave). The bus carries the Wishbone slave signals and
// the BRAM port.
// Optional macro WB_BRAM_RANGE_ERR_EN: a decode hit whose offset lies
// outside the BRAM is answered with a one-cycle wbs_err_o and no BRAM
// access. Without the macro, wbs_err_o is tied low and such offsets alias
// into the BRAM.
//
// state | meaning
// IDLE  | waiting for cyc & stb & decode hit
// WAIT  | counting down the programmed delay; cyc drop aborts
// ISSUE | bram_en high for one cycle, write strobes applied
// CAPT  | read data from BRAM registered into wbs_dat_o
// ACK   | ack (or err) presented while cyc is still held
module wb_bram_ctrl
    import wb_bram_pkg::*;
#(
    parameter int          DELAY     = 10,
    parameter int          N         = 14,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK
) (
    input  logic            wb_clk_i,
    input  logic            wb_rstn_i,
    wb_bram_ctrl_if.slave   bus
);
    localparam logic [2:0]  S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0]  S_WAIT   = 3'(ST_WAIT);
    localparam logic [2:0]  S_ISSUE  = 3'(ST_ISSUE);
    localparam logic [2:0]  S_CAPT   = 3'(ST_CAPT);
    localparam logic [2:0]  S_ACK    = 3'(ST_ACK);
    localparam logic [31:0] OFF_MASK = 32'((64'd1 << (N + 2)) - 64'd1);

    logic [2:0]             r_state;
    logic                   r_we;
    logic [SEL_W-1:0]       r_sel;
    logic [BRAM_WORD_W-1:0] r_di;
    logic [31:0]            r_a;
    logic [BRAM_WORD_W-1:0] r_dat_o;

    logic [31:0]            w_off;
    logic [31:0]            w_word;
    logic                   w_hit;
    logic                   w_accept;
    logic                   w_cnt_dec;
    logic                   w_cnt_zero;

    assign w_off    = bus.wbs_adr_i - BASE_ADDR;
    // Keep only the bits that address the BRAM, so bram_a[31:N] stays zero.
    assign w_word   = (w_off & OFF_MASK) >> 2;
    assign w_hit    = ((bus.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign w_accept = (r_state == S_IDLE) && bus.wbs_cyc_i && bus.wbs_stb_i && w_hit;
    assign w_cnt_dec = (r_state == S_WAIT) && bus.wbs_cyc_i && !w_cnt_zero;

`ifdef WB_BRAM_RANGE_ERR_EN
    logic r_err;
    logic w_in_range;
    assign w_in_range = ((w_off >> (N + 2)) == 32'd0);
`endif

    wb_bram_delay_cnt #(.DELAY(DELAY)) u_delay_cnt (
        .i_clk  (wb_clk_i),
        .i_rstn (wb_rstn_i),
        .i_load (w_accept),
        .i_dec  (w_cnt_dec),
        .o_zero (w_cnt_zero)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_di    <= '0;
            r_a     <= '0;
            r_dat_o <= '0;
`ifdef WB_BRAM_RANGE_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
`ifdef WB_BRAM_RANGE_ERR_EN
                        if (!w_in_range) begin
                            r_err   <= 1'b1;
                            r_state <= S_ACK;
                        end else begin
                            r_err   <= 1'b0;
                            r_we    <= bus.wbs_we_i;
                            r_sel   <= bus.wbs_sel_i;
                            r_di    <= bus.wbs_dat_i;
                            r_a     <= w_word;
                            r_state <= S_WAIT;
                        end
`else
                        r_we    <= bus.wbs_we_i;
                        r_sel   <= bus.wbs_sel_i;
                        r_di    <= bus.wbs_dat_i;
                        r_a     <= w_word;
                        r_state <= S_WAIT;
`endif
                    end
                end
                S_WAIT: begin
                    if (!bus.wbs_cyc_i)
                        r_state <= S_IDLE;
                    else if (w_cnt_zero)
                        r_state <= S_ISSUE;
                end
                S_ISSUE: r_state <= S_CAPT;
                S_CAPT: begin
                    if (!r_we)
                        r_dat_o <= bus.bram_do;
                    r_state <= S_ACK;
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The master may drop cyc after WAIT. In that case the response is
    // suppressed, but a write already issued to the BRAM stays done.
`ifdef WB_BRAM_RANGE_ERR_EN
    assign bus.wbs_ack_o = (r_state == S_ACK) && bus.wbs_cyc_i && !r_err;
    assign bus.wbs_err_o = (r_state == S_ACK) && bus.wbs_cyc_i && r_err;
`else
    assign bus.wbs_ack_o = (r_state == S_ACK) && bus.wbs_cyc_i;
    assign bus.wbs_err_o = 1'b0;
`endif
    assign bus.wbs_dat_o = r_dat_o;
    assign bus.bram_en   = (r_state == S_ISSUE);
    assign bus.bram_we   = ((r_state == S_ISSUE) && r_we) ? r_sel : '0;
    assign bus.bram_di   = r_di;
    assign bus.bram_a    = r_a;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Scoreboard bench for wb_bram_ctrl.
// Each request pushes its expected BRAM access and its expected bus response
// into queues. Monitors sample on the falling edge and pop/compare whenever
// the DUT shows bram_en, ack or err.
// Latencies are counted in rising edges from the accepting edge to the edge
// that starts the output cycle: bram_en at DELAY, ack at DELAY+2, err at 0.
module tb_wb_bram_ctrl;
    localparam int DELAY = 10;

    typedef struct {
        logic        is_err;
        logic        chk_data;
        logic [31:0] data;
        int          acc_edge;
        int          lat;
    } ack_exp_t;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] a;
        logic [31:0] di;
        int          acc_edge;
    } bram_exp_t;

    logic clk;
    logic rstn;
    int   edge_cnt = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [31:0] mem [0:16383];

    ack_exp_t  ack_q[$];
    bram_exp_t bram_q[$];

    wb_bram_ctrl_if bif ();

    wb_bram_ctrl #(.DELAY(DELAY)) dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rstn),
        .bus       (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt++;

    // BRAM model: read-first, Do forced to 0 whenever EN is low.
    always @(posedge clk) begin
        if (bif.bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bif.bram_we[b]) mem[bif.bram_a[13:0]][b*8 +: 8] <= bif.bram_di[b*8 +: 8];
            bif.bram_do <= mem[bif.bram_a[13:0]];
        end else begin
            bif.bram_do <= 32'h0;
        end
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // Response monitor
    always @(negedge clk) begin
        if (bif.wbs_ack_o || bif.wbs_err_o) begin
            check("resp_expected", 32'(ack_q.size() != 0), 32'd1);
            if (ack_q.size() != 0) begin
                ack_exp_t e;
                e = ack_q.pop_front();
                check("resp_is_err", 32'(bif.wbs_err_o), 32'(e.is_err));
                check("resp_is_ack", 32'(bif.wbs_ack_o), 32'(!e.is_err));
                check("resp_latency", 32'(edge_cnt - e.acc_edge), 32'(e.lat));
                if (e.chk_data) check("read_data", bif.wbs_dat_o, e.data);
            end
        end
    end

    // BRAM access monitor
    always @(negedge clk) begin
        if (!bif.bram_en && bif.bram_we != 4'h0)
            check("we_outside_issue", 32'(bif.bram_we), 32'h0);
        if (bif.bram_en) begin
            check("bram_expected", 32'(bram_q.size() != 0), 32'd1);
            if (bram_q.size() != 0) begin
                bram_exp_t e;
                e = bram_q.pop_front();
                check("bram_we", 32'(bif.bram_we), 32'(e.we));
                check("bram_a", bif.bram_a, e.a);
                check("bram_di", bif.bram_di, e.di);
                check("bram_latency", 32'(edge_cnt - e.acc_edge), 32'(DELAY));
            end
        end
    end

    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        bif.wbs_cyc_i = 1'b1;
        bif.wbs_stb_i = 1'b1;
        bif.wbs_we_i  = we;
        bif.wbs_adr_i = adr;
        bif.wbs_dat_i = dat;
        bif.wbs_sel_i = sel;
    endtask

    task automatic release_bus();
        bif.wbs_cyc_i = 1'b0;
        bif.wbs_stb_i = 1'b0;
        bif.wbs_we_i  = 1'b0;
    endtask

    task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp_a,
                       input logic [31:0] exp_rd, input logic exp_err);
        int  acc;
        bit  done;
        @(negedge clk);
        drive(we, adr, dat, sel);
        acc = edge_cnt + 1;
        if (exp_err) begin
            ack_q.push_back('{1'b1, 1'b0, 32'h0, acc, 0});
        end else begin
            ack_q.push_back('{1'b0, !we, exp_rd, acc, DELAY + 2});
            bram_q.push_back('{we ? sel : 4'h0, exp_a, dat, acc});
        end
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (bif.wbs_ack_o || bif.wbs_err_o) done = 1;
        end
        check("resp_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1 release_bus();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},  32'(bif.wbs_ack_o), 32'h0);
        check({tag, "_err"},  32'(bif.wbs_err_o), 32'h0);
        check({tag, "_dat"},  bif.wbs_dat_o, 32'h0);
        check({tag, "_en"},   32'(bif.bram_en), 32'h0);
        check({tag, "_we"},   32'(bif.bram_we), 32'h0);
        check({tag, "_a"},    bif.bram_a, 32'h0);
        check({tag, "_di"},   bif.bram_di, 32'h0);
    endtask

    initial begin
        int acc;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        rstn = 1'b0;
        release_bus();
        bif.wbs_adr_i = 32'h0;
        bif.wbs_dat_i = 32'h0;
        bif.wbs_sel_i = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;

        // Full write, read back, partial write, read back
        req(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 32'h4, 32'h0, 1'b0);
        req(1'b0, 32'h3800_0010, 32'h0,         4'hF, 32'h4, 32'hDEAD_BEEF, 1'b0);
        req(1'b1, 32'h3800_0010, 32'h0000_AA00, 4'h2, 32'h4, 32'h0, 1'b0);
        req(1'b0, 32'h3800_0010, 32'h0,         4'hF, 32'h4, 32'hDEAD_AAEF, 1'b0);

        // Accept, then abort in WAIT: no BRAM pulse, no response
        @(negedge clk);
        drive(1'b1, 32'h3800_0010, 32'h1234_5678, 4'hF);
        idle_cycles(3);
        release_bus();
        idle_cycles(20);
        req(1'b0, 32'h3800_0010, 32'h0, 4'hF, 32'h4, 32'hDEAD_AAEF, 1'b0);

`ifdef WB_BRAM_RANGE_ERR_EN
        req(1'b0, 32'h3801_0000, 32'h0, 4'hF, 32'h0, 32'h0, 1'b1);
        req(1'b0, 32'h3800_0010, 32'h0, 4'hF, 32'h4, 32'hDEAD_AAEF, 1'b0);
`else
        // Out-of-range offset aliases onto word 4
        req(1'b1, 32'h3801_0010, 32'h0BAD_F00D, 4'hC, 32'h4, 32'h0, 1'b0);
        req(1'b0, 32'h3800_0010, 32'h0, 4'hF, 32'h4, 32'h0BAD_AAEF, 1'b0);
`endif

        // Last word of the window
        req(1'b1, 32'h3800_FFFC, 32'hCAFE_F00D, 4'hF, 32'h3FFF, 32'h0, 1'b0);
        req(1'b0, 32'h3800_FFFC, 32'h0, 4'hF, 32'h3FFF, 32'hCAFE_F00D, 1'b0);

        // Decode miss held for 20 cycles
        @(negedge clk);
        drive(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        idle_cycles(20);
        release_bus();
        idle_cycles(2);

        // Reset asserted during ISSUE
        @(negedge clk);
        drive(1'b1, 32'h3800_0020, 32'h55AA_55AA, 4'hF);
        acc = edge_cnt + 1;
        bram_q.push_back('{4'hF, 32'h8, 32'h55AA_55AA, acc});
        for (int i = 0; i < 40 && edge_cnt != acc + DELAY; i++) @(negedge clk);
        check("issue_reached", 32'(bif.bram_en), 32'd1);
        rstn = 1'b0;
        release_bus();
        @(negedge clk);
        check_all_zero("mid_reset");
        @(negedge clk);
        rstn = 1'b1;
        idle_cycles(20);

        check("ack_q_drained", 32'(ack_q.size()), 32'd0);
        check("bram_q_drained", 32'(bram_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
